// File: rtl/apb_ram_completer.sv
// APB completer backed by a word-addressed RAM. Wait states are programmable,
// misaligned or out-of-window accesses raise pslverr, and dropping psel aborts a transfer.
module apb_ram_completer #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        APB_psel,
    input  logic        APB_penable,
    input  logic        APB_pwrite,
    input  logic [31:0] APB_paddr,
    input  logic [31:0] APB_pwdata,
    output logic [31:0] APB_prdata,
    output logic        APB_pready,
    output logic        APB_pslverr
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [AW-1:0] idx_q, idx_nxt;
    logic [31:0]   wdata_q, wdata_nxt;
    logic          write_q, write_nxt;
    logic          err_q, err_nxt;

    logic          pready_nxt;
    logic          pslverr_nxt;
    logic [31:0]   prdata_nxt;
    logic          mem_we;

    logic [31:0]   mem [DEPTH];

    logic          setup;
    logic [32:0]   offset;
    logic          addr_err;

    assign setup  = APB_psel && !APB_penable;
    // 33-bit offset so an address below BASE_ADDR cannot wrap into the window.
    assign offset = {1'b0, APB_paddr} - {1'b0, BASE_ADDR};
    assign addr_err = (APB_paddr[1:0] != 2'b00) || (APB_paddr < BASE_ADDR) || (offset >= SPAN);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx_q;
        wdata_nxt = wdata_q;
        write_nxt = write_q;
        err_nxt   = err_q;
        mem_we    = 1'b0;

        case (state)
            IDLE: begin
                if (setup) begin
                    idx_nxt   = offset[AW+1:2];
                    wdata_nxt = APB_pwdata;
                    write_nxt = APB_pwrite;
                    err_nxt   = addr_err;
                    cnt_nxt   = WS_LOAD;
                    state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (!APB_psel) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
                mem_we    = APB_psel && write_q && !err_q;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase

        // Outputs are registered: they reflect the state being entered.
        pready_nxt  = (state_nxt == ACCESS);
        pslverr_nxt = pready_nxt && err_nxt;
        prdata_nxt  = (pready_nxt && !write_nxt && !err_nxt) ? mem[idx_nxt] : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= 32'h0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            APB_pready  <= 1'b0;
            APB_pslverr <= 1'b0;
            APB_prdata  <= 32'h0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx_q       <= idx_nxt;
            wdata_q     <= wdata_nxt;
            write_q     <= write_nxt;
            err_q       <= err_nxt;
            APB_pready  <= pready_nxt;
            APB_pslverr <= pslverr_nxt;
            APB_prdata  <= prdata_nxt;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_ram_completer.sv
// Bench for apb_ram_completer: three instances (0, 1 and 3 wait states) driven by
// a directed vector table, hand-written abort/reset sequences and random traffic.
module tb_apb_ram_completer;

    localparam int NI    = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel    [NI];
    logic        penable [NI];
    logic        pwrite  [NI];
    logic [31:0] paddr   [NI];
    logic [31:0] pwdata  [NI];
    logic [31:0] prdata  [NI];
    logic        pready  [NI];
    logic        pslverr [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        apb_ram_completer #(
            .DEPTH(DEPTH),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3)),
            .BASE_ADDR(32'h0000_0000)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .APB_psel(psel[g]),
            .APB_penable(penable[g]),
            .APB_pwrite(pwrite[g]),
            .APB_paddr(paddr[g]),
            .APB_pwdata(pwdata[g]),
            .APB_prdata(prdata[g]),
            .APB_pready(pready[g]),
            .APB_pslverr(pslverr[g])
        );
    end

    int total = 0;
    int bad   = 0;

    // Reference memory: word contents plus a flag for words with known contents.
    logic [31:0] mm [NI][DEPTH];
    bit          kn [NI][DEPTH];

    typedef struct {
        int          k;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          exp_er;
        bit          gap;
    } vec_t;

    vec_t tbl [16];

    function automatic int ws_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic bit addr_bad(logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_apply(int k, bit wr, logic [31:0] a, logic [31:0] d);
        if (wr && !addr_bad(a)) begin
            mm[k][a[11:2]] = d;
            kn[k][a[11:2]] = 1'b1;
        end
    endtask

    // Setup at a falling edge, access phase until pready; returns at the falling
    // edge inside the ACCESS cycle with the bus still driven.
    task automatic xfer(int k, bit wr, logic [31:0] a, logic [31:0] d,
                        output logic [31:0] rd, output bit er, output int waits);
        bit done;
        rd = 32'h0; er = 1'b0; waits = 0; done = 1'b0;
        @(negedge clk);
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
        @(negedge clk);
        penable[k] = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (pready[k] === 1'b1) begin
                rd = prdata[k];
                er = pslverr[k];
                done = 1'b1;
            end else begin
                chk($sformatf("quiet_outputs_i%0d", k), prdata[k] | {31'h0, pslverr[k]}, 32'h0);
                waits++;
                paddr[k]  = $urandom;
                pwdata[k] = $urandom;
                @(negedge clk);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout_i%0d: pready=%b required 1", k, pready[k]);
        end
    endtask

    task automatic idle(int k);
        @(negedge clk);
        psel[k] = 1'b0;
        penable[k] = 1'b0;
    endtask

    task automatic do_chk(int k, bit wr, logic [31:0] a, logic [31:0] d, string tag);
        logic [31:0] rd;
        bit          er;
        int          w;
        bit          ee;
        ee = addr_bad(a);
        xfer(k, wr, a, d, rd, er, w);
        chk({tag, "_err"}, {31'h0, er}, {31'h0, ee});
        chk({tag, "_waits"}, w, ws_of(k));
        if (wr || ee) chk({tag, "_rdata0"}, rd, 32'h0);
        else if (kn[k][a[11:2]]) chk({tag, "_rdata"}, rd, mm[k][a[11:2]]);
        model_apply(k, wr, a, d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          er;
        int          w;
        int          last_k;
        logic [31:0] a;

        for (int i = 0; i < NI; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = 32'h0; pwdata[i] = 32'h0;
            for (int j = 0; j < DEPTH; j++) begin
                mm[i][j] = 32'h0;
                kn[i][j] = 1'b0;
            end
        end

        tbl[0]  = '{1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1};
        tbl[1]  = '{1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[2]  = '{0, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0,         1'b0, 1'b1};
        tbl[3]  = '{0, 1'b1, 32'h0000_0004, 32'h2222_2222, 32'h0,         1'b0, 1'b0};
        tbl[4]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0, 1'b0};
        tbl[5]  = '{0, 1'b0, 32'h0000_0004, 32'h0,         32'h2222_2222, 1'b0, 1'b0};
        tbl[6]  = '{1, 1'b1, 32'h0000_0FFC, 32'h55AA_55AA, 32'h0,         1'b0, 1'b1};
        tbl[7]  = '{1, 1'b0, 32'h0000_0006, 32'h0,         32'h0,         1'b1, 1'b0};
        tbl[8]  = '{1, 1'b1, 32'h0000_1000, 32'h9999_9999, 32'h0,         1'b1, 1'b0};
        tbl[9]  = '{1, 1'b0, 32'h0000_0FFC, 32'h0,         32'h55AA_55AA, 1'b0, 1'b0};
        tbl[10] = '{2, 1'b1, 32'h0000_0020, 32'h0BAD_BEEF, 32'h0,         1'b0, 1'b1};
        tbl[11] = '{2, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0,         1'b0, 1'b0};
        tbl[12] = '{2, 1'b1, 32'h0000_0008, 32'hAAAA_0000, 32'h0,         1'b0, 1'b0};
        tbl[13] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1, 1'b1};
        tbl[14] = '{0, 1'b1, 32'h0000_0004, 32'h3333_3333, 32'h0,         1'b0, 1'b0};
        tbl[15] = '{0, 1'b0, 32'h0000_0004, 32'h0,         32'h3333_3333, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_pready_i%0d", i), {31'h0, pready[i]}, 32'h0);
            chk($sformatf("reset_pslverr_i%0d", i), {31'h0, pslverr[i]}, 32'h0);
            chk($sformatf("reset_prdata_i%0d", i), prdata[i], 32'h0);
        end
        rst_n = 1'b1;

        // Directed table, rows without gap run back-to-back
        last_k = -1;
        foreach (tbl[r]) begin
            if (tbl[r].gap && last_k >= 0) idle(last_k);
            xfer(tbl[r].k, tbl[r].wr, tbl[r].a, tbl[r].d, rd, er, w);
            chk($sformatf("tbl%0d_rdata", r), rd, tbl[r].exp_rd);
            chk($sformatf("tbl%0d_err", r), {31'h0, er}, {31'h0, tbl[r].exp_er});
            chk($sformatf("tbl%0d_waits", r), w, ws_of(tbl[r].k));
            model_apply(tbl[r].k, tbl[r].wr, tbl[r].a, tbl[r].d);
            last_k = tbl[r].k;
        end
        idle(last_k);

        // penable without a setup cycle must not start a transfer
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1;
        paddr[1] = 32'h10; pwdata[1] = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("no_setup_pready", {31'h0, pready[1]}, 32'h0);
        end
        psel[1] = 1'b0; penable[1] = 1'b0;
        do_chk(1, 1'b0, 32'h10, 32'h0, "no_setup_readback");
        idle(1);

        // psel dropped in the second wait cycle of a 3-wait-state write
        @(negedge clk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h20; pwdata[2] = 32'hCAFE_F00D;
        @(negedge clk);
        penable[2] = 1'b1;
        @(negedge clk);
        psel[2] = 1'b0; penable[2] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_pready", {31'h0, pready[2]}, 32'h0);
        end
        do_chk(2, 1'b0, 32'h20, 32'h0, "abort_readback");
        idle(2);

        // Reset pulse inside the ACCESS cycle: outputs clear at once, write is dropped
        for (int wr = 0; wr < 2; wr++) begin
            xfer(1, 1'(wr), 32'h10, 32'h7777_7777, rd, er, w);
            chk("acc_rst_pre_rdata", rd, (wr == 0) ? 32'hDEAD_BEEF : 32'h0);
            #2 rst_n = 1'b0;
            #1;
            chk("acc_rst_pready", {31'h0, pready[1]}, 32'h0);
            chk("acc_rst_prdata", prdata[1], 32'h0);
            #1 rst_n = 1'b1;
            idle(1);
        end
        do_chk(1, 1'b0, 32'h10, 32'h0, "acc_rst_readback");
        idle(1);

        // Reset pulse during WAIT of a write on the 3-wait-state instance
        @(negedge clk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h8; pwdata[2] = 32'h1234_5678;
        @(negedge clk);
        penable[2] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("wait_rst_pready", {31'h0, pready[2]}, 32'h0);
        chk("wait_rst_pslverr", {31'h0, pslverr[2]}, 32'h0);
        chk("wait_rst_prdata", prdata[2], 32'h0);
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_chk(2, 1'b0, 32'h8, 32'h0, "post_rst_rd8");
        do_chk(2, 1'b0, 32'h0, 32'h0, "post_rst_rd0");
        idle(2);
        do_chk(0, 1'b0, 32'h0, 32'h0, "post_rst_i0_rd0");
        idle(0);

        // Random traffic against the reference model
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 100; n++) begin
                int unsigned r;
                r = $urandom_range(0, 9);
                if (r < 7)       a = 32'($urandom_range(0, 31)) << 2;
                else if (r == 7) a = (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(1, 3));
                else if (r == 8) a = 32'h1000 + (32'($urandom_range(0, 31)) << 2);
                else             a = $urandom & 32'hFFFF_FFFC;
                do_chk(k, 1'($urandom_range(0, 1)), a, $urandom, $sformatf("rnd_i%0d", k));
                if ($urandom_range(0, 1) == 1) idle(k);
            end
            idle(k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_ram_completer.md
APB_RAM_COMPLETER -- requirements
Module: apb_ram_completer

Interface
REQ-001 SHALL provide parameter DEPTH, default 1024, memory size in 32-bit words (power of two).
REQ-002 SHALL provide parameter WAIT_STATES, default 1, access-phase cycles with APB_pready low (range 0..15).
REQ-003 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-004 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: APB_psel  input  1  completer selected.
REQ-007 SHALL have port: APB_penable  input  1  access phase.
REQ-008 SHALL have port: APB_pwrite  input  1  1 = write, 0 = read.
REQ-009 SHALL have port: APB_paddr  input  32  byte address.
REQ-010 SHALL have port: APB_pwdata  input  32  write data.
REQ-011 SHALL have port: APB_prdata  output  32  read data.
REQ-012 SHALL have port: APB_pready  output  1  transfer complete.
REQ-013 SHALL have port: APB_pslverr  output  1  transfer error.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACCESS; APB_pready, APB_prdata, APB_pslverr SHALL be registered.
REQ-015 IDLE: APB_psel=1 and APB_penable=0 (setup) SHALL latch paddr, pwdata, pwrite and error flag, load wait counter with WAIT_STATES, and go to WAIT if WAIT_STATES>0, else ACCESS.
REQ-016 IDLE SHALL ignore APB_penable=1 without a preceding setup cycle.
REQ-017 WAIT: APB_pready=0; counter decrements each cycle; at counter==1 next state ACCESS, so exactly WAIT_STATES access cycles show APB_pready=0.
REQ-018 ACCESS: APB_pready=1 for exactly one cycle; next state IDLE unconditionally.
REQ-019 Error flag SHALL be set when paddr[1:0]!=0 or paddr outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
REQ-020 ACCESS read, no error: APB_prdata = mem[(paddr-BASE_ADDR)>>2].
REQ-021 ACCESS write, no error: mem word updated at the clock edge ending the ACCESS cycle.
REQ-022 ACCESS with error: APB_pslverr=1, APB_prdata=0, no memory update.
REQ-023 APB_pslverr and APB_prdata SHALL be 0 in every cycle where APB_pready=0.
REQ-024 APB_psel=0 while in WAIT or ACCESS SHALL abort: next state IDLE, no memory update, outputs 0 next cycle.
REQ-025 Back-to-back: a setup cycle immediately following the ACCESS cycle SHALL be accepted from IDLE with no lost transfer.
REQ-026 Read following a write to the same word SHALL return the new data.
REQ-027 Address/data changes during WAIT SHALL be ignored (latched values used).

Reset
REQ-028 rst_n=0 SHALL force IDLE, counter 0, APB_pready=0, APB_pslverr=0, APB_prdata=0 immediately, regardless of clk.
REQ-029 Reset mid-transfer SHALL discard the pending transfer without memory update; memory contents SHALL NOT be cleared by reset.
REQ-030 First setup cycle SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-031 WAIT_STATES=1: write 0xDEADBEEF to 0x10, then read 0x10 -> pready low 1 access cycle each, prdata=0xDEADBEEF, pslverr=0.
REQ-032 WAIT_STATES=0: back-to-back writes 0x11111111@0x0, 0x22222222@0x4, reads of both -> each transfer 2 cycles, correct data, no gap needed.
REQ-033 Misaligned read 0x6 and out-of-range write 0x1000 (DEPTH=1024 -> 0x1000 valid limit) -> pslverr=1, prdata=0, mem[0x1000-4] unchanged on later read.
REQ-034 WAIT_STATES=3: psel dropped in second wait cycle of write 0xCAFEF00D@0x20 -> IDLE, later read of 0x20 returns prior value.
REQ-035 rst_n pulsed low mid-WAIT of write 0x12345678@0x8 -> outputs 0 asynchronously, mem[0x8] unchanged; post-reset read of previously written 0x0 returns 0x11111111.
